// File: rtl/pipe_dbg_pkg.sv
// Shared definitions for the pipeline type scanner: opcodes, ASCII codes,
// scanner state type and the default stage count.
package pipe_dbg_pkg;

  localparam int NUM_STAGES_DEF = 5;

  // RV32 major opcodes recognised by the type decoder
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // ASCII characters used in the frame
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_R  = 8'h52;
  localparam logic [7:0] ASC_I  = 8'h49;
  localparam logic [7:0] ASC_L  = 8'h4C;
  localparam logic [7:0] ASC_S  = 8'h53;
  localparam logic [7:0] ASC_B  = 8'h42;
  localparam logic [7:0] ASC_J  = 8'h4A;
  localparam logic [7:0] ASC_U  = 8'h55;
  localparam logic [7:0] ASC_X  = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT_HI  = 2'd1,
    ST_EMIT_LO  = 2'd2,
    ST_EMIT_EOL = 2'd3
  } scan_state_e;

endpackage

// File: rtl/instr_type_decode.sv
// Combinational opcode -> two-character instruction type code {hi, lo}.
module instr_type_decode
  import pipe_dbg_pkg::*;
(
  input  logic [6:0]  i_opcode,
  output logic [15:0] o_code
);

  // Map each known opcode to its ASCII tag; anything else is " X"
  always_comb begin
    o_code = {ASC_SP, ASC_X};
    case (i_opcode)
      OP_R:    o_code = {ASC_SP, ASC_R};
      OP_I:    o_code = {ASC_SP, ASC_I};
      OP_LOAD: o_code = {ASC_I,  ASC_L};
      OP_S:    o_code = {ASC_SP, ASC_S};
      OP_B:    o_code = {ASC_SP, ASC_B};
      OP_JAL:  o_code = {ASC_SP, ASC_J};
      OP_JALR: o_code = {ASC_I,  ASC_J};
      OP_LUI:  o_code = {ASC_SP, ASC_U};
      default: o_code = {ASC_SP, ASC_X};
    endcase
  end

endmodule

// File: rtl/pipe_type_scanner.sv
// Pipeline type scanner: snapshots the opcode of every pipeline stage on
// start and streams a frame of two ASCII characters per stage followed by
// a CR terminator over a valid/ready character interface.
module pipe_type_scanner
  import pipe_dbg_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_STAGES-1:0][6:0]  stage_op,
  input  logic                        char_ready,
  output logic                        char_valid,
  output logic [7:0]                  char_data,
  output logic                        char_last,
  output logic                        busy
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  scan_state_e                r_state;
  scan_state_e                w_state_nxt;
  logic [IDX_W-1:0]           r_stage_idx;
  logic [IDX_W-1:0]           w_idx_nxt;
  logic [NUM_STAGES-1:0][6:0] r_snap;
  logic [6:0]                 w_dec_op;
  logic [15:0]                w_code;
  logic                       r_char_valid;
  logic [7:0]                 r_char_data;
  logic                       r_char_last;
  logic                       r_busy;

  // Next-state and next-stage selection; abort overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_stage_idx;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_EMIT_HI;
          w_idx_nxt   = '0;
        end
      end
      ST_EMIT_HI: begin
        if (char_ready) w_state_nxt = ST_EMIT_LO;
      end
      ST_EMIT_LO: begin
        if (char_ready) begin
          if (r_stage_idx < LAST_IDX) begin
            w_state_nxt = ST_EMIT_HI;
            w_idx_nxt   = r_stage_idx + 1'b1;
          end else begin
            w_state_nxt = ST_EMIT_EOL;
          end
        end
      end
      ST_EMIT_EOL: begin
        if (char_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end
  end

  // The single decoder looks at the stage whose characters are loaded next.
  // Leaving IDLE the snapshot is not yet written, so stage 0 comes from the
  // live input (the same value being captured into the snapshot).
  assign w_dec_op = (r_state == ST_IDLE) ? stage_op[0] : r_snap[w_idx_nxt];

  instr_type_decode u_decode (
    .i_opcode (w_dec_op),
    .o_code   (w_code)
  );

  // FSM state, stage counter and opcode snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_stage_idx <= '0;
      r_snap      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stage_idx <= w_idx_nxt;
      if (r_state == ST_IDLE && start && !abort) r_snap <= stage_op;
    end
  end

  // Output registers loaded from the state being entered, so they only
  // change on an accepted handshake and hold steady through stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_char_valid <= 1'b0;
      r_char_data  <= 8'h00;
      r_char_last  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      case (w_state_nxt)
        ST_EMIT_HI: begin
          r_char_valid <= 1'b1;
          r_char_data  <= w_code[15:8];
          r_char_last  <= 1'b0;
        end
        ST_EMIT_LO: begin
          r_char_valid <= 1'b1;
          r_char_data  <= w_code[7:0];
          r_char_last  <= 1'b0;
        end
        ST_EMIT_EOL: begin
          r_char_valid <= 1'b1;
          r_char_data  <= ASC_CR;
          r_char_last  <= 1'b1;
        end
        default: begin
          r_char_valid <= 1'b0;
          r_char_data  <= 8'h00;
          r_char_last  <= 1'b0;
        end
      endcase
    end
  end

  assign char_valid = r_char_valid;
  assign char_data  = r_char_data;
  assign char_last  = r_char_last;
  assign busy       = r_busy;

endmodule

// File: tb/tb_pipe_type_scanner.sv
// Self-checking bench for pipe_type_scanner with a frame-level reference model.
module tb_pipe_type_scanner;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [4:0][6:0] stage_op;
  logic            char_ready;
  logic            char_valid;
  logic [7:0]      char_data;
  logic            char_last;
  logic            busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  int         stall_bad;
  int         cyc_used;
  bit         timed_out;

  localparam logic [4:0][6:0] OPS_A = {7'b1111111, 7'b1100111, 7'b0100011,
                                       7'b0000011, 7'b0110011};

  pipe_type_scanner #(.NUM_STAGES(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .stage_op   (stage_op),
    .char_ready (char_ready),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_last  (char_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: instruction type tag as a two-character string
  function automatic logic [15:0] ref_tag(input logic [6:0] op);
    case (op)
      7'b0110011: return " R";
      7'b0010011: return " I";
      7'b0000011: return "IL";
      7'b0100011: return " S";
      7'b1100011: return " B";
      7'b1101111: return " J";
      7'b1100111: return "IJ";
      7'b0110111: return " U";
      default:    return " X";
    endcase
  endfunction

  // Reference frame: tag of each stage, IF first, then CR
  function automatic void build_exp(input logic [4:0][6:0] ops);
    logic [15:0] t;
    exp_q.delete();
    for (int s = 0; s < 5; s++) begin
      t = ref_tag(ops[s]);
      exp_q.push_back(t[15:8]);
      exp_q.push_back(t[7:0]);
    end
    exp_q.push_back(8'h0D);
  endfunction

  function automatic logic [6:0] rand_op();
    logic [6:0] tbl [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    if ($urandom_range(0, 3) == 0) return 7'($urandom);
    return tbl[$urandom_range(0, 7)];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Sink: accepts characters under a ready pattern until char_last is taken
  task automatic collect(input int mode, input bit swap_ops, input int budget);
    logic [7:0] prev_data;
    logic       prev_last;
    bit         prev_stall;
    bit         done;
    int         n;
    got_q.delete();
    got_last_q.delete();
    stall_bad  = 0;
    prev_stall = 0;
    prev_data  = '0;
    prev_last  = 1'b0;
    done       = 0;
    n          = 0;
    while (n < budget && !done) begin
      if (swap_ops && n == 0) stage_op = {5{7'b0110111}};
      case (mode)
        0:       char_ready = 1'b1;
        1:       char_ready = ((n % 4) == 0) || ((n % 4) == 3);
        default: char_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall && (char_data !== prev_data || char_last !== prev_last))
        stall_bad++;
      if (char_valid === 1'b1 && char_ready) begin
        got_q.push_back(char_data);
        got_last_q.push_back(char_last);
        if (char_last === 1'b1) done = 1;
      end
      prev_stall = (char_valid === 1'b1) && !char_ready;
      prev_data  = char_data;
      prev_last  = char_last;
      step();
      n++;
    end
    cyc_used   = n;
    timed_out  = !done;
    char_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; char_ready = 1'b0; stage_op = '0;
    step(); step();
    total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", char_valid); end
    total++; if (char_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", char_data); end
    total++; if (char_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", char_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    step(); step();
    total++; if (char_valid !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL rst_release_idle: got valid=%b busy=%b want 0/0", char_valid, busy); end
  endtask

  task automatic check_frame(input string tag);
    total++; if (timed_out) begin bad++; $display("FAIL %s_timeout: got no char_last want frame end", tag); end
    total++; if (got_q.size() != 11) begin bad++; $display("FAIL %s_len: got %0d want 11", tag, got_q.size()); end
    for (int k = 0; k < got_q.size() && k < 11; k++) begin
      total++; if (got_q[k] !== exp_q[k])
        begin bad++; $display("FAIL %s_char%0d: got %h want %h", tag, k, got_q[k], exp_q[k]); end
      total++; if (got_last_q[k] !== (k == 10))
        begin bad++; $display("FAIL %s_last%0d: got %b want %b", tag, k, got_last_q[k], (k == 10)); end
    end
  endtask

  task automatic test_basic();
    stage_op = OPS_A;
    build_exp(OPS_A);
    kick();
    total++; if (char_valid !== 1'b1 || busy !== 1'b1)
      begin bad++; $display("FAIL basic_latency: got valid=%b busy=%b want 1/1", char_valid, busy); end
    collect(0, 0, 40);
    check_frame("basic");
    total++; if (cyc_used != 11) begin bad++; $display("FAIL basic_consecutive: got %0d cycles want 11", cyc_used); end
    total++; if (busy !== 1'b0 || char_valid !== 1'b0)
      begin bad++; $display("FAIL basic_busy_drop: got busy=%b valid=%b want 0/0", busy, char_valid); end
  endtask

  task automatic test_stall();
    stage_op = OPS_A;
    build_exp(OPS_A);
    kick();
    collect(1, 0, 100);
    check_frame("stall");
    total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", stall_bad); end
  endtask

  task automatic test_snapshot();
    stage_op = OPS_A;
    build_exp(OPS_A);
    kick();
    collect(0, 1, 40);
    check_frame("snap");
    stage_op = OPS_A;
  endtask

  task automatic test_random();
    logic [4:0][6:0] ops;
    for (int f = 0; f < 6; f++) begin
      for (int s = 0; s < 5; s++) ops[s] = rand_op();
      stage_op = ops;
      build_exp(ops);
      kick();
      stage_op = 35'($urandom) ^ {35{1'b1}};
      collect(2, 0, 300);
      check_frame("rand");
      total++; if (stall_bad != 0) begin bad++; $display("FAIL rand_stable: got %0d changes want 0", stall_bad); end
      step();
    end
  endtask

  task automatic test_abort();
    int vcount;
    stage_op = OPS_A;
    build_exp(OPS_A);
    kick();
    char_ready = 1'b1;
    for (int j = 0; j < 4; j++) step();
    total++; if (char_data !== exp_q[4] || char_valid !== 1'b1)
      begin bad++; $display("FAIL abort_pre: got %h/%b want %h/1", char_data, char_valid, exp_q[4]); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++; if (char_valid !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL abort_stop: got valid=%b busy=%b want 0/0", char_valid, busy); end
    vcount = 0;
    for (int j = 0; j < 15; j++) begin
      if (char_valid === 1'b1) vcount++;
      step();
    end
    total++; if (vcount != 0) begin bad++; $display("FAIL abort_no_tail: got %0d valid cycles want 0", vcount); end
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    total++; if (char_valid !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL abort_priority: got valid=%b busy=%b want 0/0", char_valid, busy); end
    kick();
    collect(0, 0, 40);
    check_frame("abort_restart");
  endtask

  task automatic test_reset_mid();
    int vcount;
    stage_op = OPS_A;
    build_exp(OPS_A);
    kick();
    char_ready = 1'b1;
    for (int j = 0; j < 5; j++) step();
    char_ready = 1'b0;
    total++; if (char_data !== exp_q[5]) begin bad++; $display("FAIL rmid_pre: got %h want %h", char_data, exp_q[5]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (char_valid !== 1'b0 || char_data !== 8'h00 || char_last !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL rmid_async: got v=%b d=%h l=%b b=%b want 0/00/0/0", char_valid, char_data, char_last, busy); end
    step(); step();
    #3 rst_n = 1'b1;
    char_ready = 1'b1;
    vcount = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (char_valid === 1'b1 || busy === 1'b1) vcount++;
    end
    total++; if (vcount != 0) begin bad++; $display("FAIL rmid_no_resume: got %0d active cycles want 0", vcount); end
    kick();
    collect(0, 0, 40);
    check_frame("rmid_restart");
  endtask

  task automatic test_back_to_back();
    logic [4:0][6:0] ops;
    int ph;
    int b;
    for (int s = 0; s < 5; s++) ops[s] = rand_op();
    stage_op = ops;
    build_exp(ops);
    char_ready = 1'b1;
    start = 1'b1;
    step();
    for (int c = 0; c < 36; c++) begin
      ph = c % 12;
      total++; if (char_valid !== (ph != 11))
        begin bad++; $display("FAIL b2b_valid%0d: got %b want %b", c, char_valid, (ph != 11)); end
      if (ph != 11) begin
        total++; if (char_data !== exp_q[ph] || char_last !== (ph == 10))
          begin bad++; $display("FAIL b2b_char%0d: got %h/%b want %h/%b", c, char_data, char_last, exp_q[ph], (ph == 10)); end
      end
      step();
    end
    start = 1'b0;
    b = 0;
    while (busy === 1'b1 && b < 40) begin step(); b++; end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_drain: got busy=%b want 0", busy); end
    char_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_snapshot();
    test_random();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
